// File: rtl/alu_execute_unit_pkg.sv
// Shared ALU control encodings, also imported by the ALU control decoder.
// Holds the output-slice state type for the execute stage.
package alu_ctrl_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;

   // ALUOp from the main decoder: load/store add, branch subtract, R-type by funct
   typedef enum logic [1:0] {
      ALUOP_MEM    = 2'b00,
      ALUOP_BRANCH = 2'b01,
      ALUOP_FUNCT  = 2'b10
   } aluop_e;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } slice_state_e;

endpackage

// File: rtl/alu_execute_unit_if.sv
// Execute-stage bus: input handshake with operands, output handshake with result and flags.
// master = surrounding pipeline, slave = alu_execute_unit.
interface alu_execute_unit_if #(
   parameter int unsigned XLEN  = 64,
   parameter int unsigned CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       alu_ctrl;
   logic [XLEN-1:0]  operand_a;
   logic [XLEN-1:0]  operand_b;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  result;
   logic             zero;
   logic             illegal;
   logic [CNT_W-1:0] op_count;

   modport master (
      output in_valid, alu_ctrl, operand_a, operand_b, out_ready,
      input  in_ready, out_valid, result, zero, illegal, op_count
   );

   modport slave (
      input  in_valid, alu_ctrl, operand_a, operand_b, out_ready,
      output in_ready, out_valid, result, zero, illegal, op_count
   );
endinterface

// File: rtl/alu_execute_unit_core.sv
// Combinational ALU datapath: AND/OR/ADD/SUB, zero and illegal-code flags.
module alu_core
   import alu_ctrl_pkg::*;
#(
   parameter int unsigned XLEN = 64
) (
   input  logic [3:0]      alu_ctrl_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic [XLEN-1:0] result_o,
   output logic            zero_o,
   output logic            illegal_o
);

   always_comb begin
      result_o  = '0;
      illegal_o = 1'b0;
      // Any unlisted code, including X/Z in simulation, lands in default
      case (alu_ctrl_i)
         ALU_AND: result_o = a_i & b_i;
         ALU_OR:  result_o = a_i | b_i;
         ALU_ADD: result_o = a_i + b_i;
         ALU_SUB: result_o = a_i - b_i;
         default: illegal_o = 1'b1;
      endcase
      zero_o = !illegal_o && (result_o == '0);
   end

endmodule

// File: rtl/alu_execute_unit.sv
// Execute-stage ALU with a 1-entry registered output slice, valid/ready on both sides,
// and a counter of completed output transfers.
module alu_execute_unit
   import alu_ctrl_pkg::*;
#(
   parameter int unsigned XLEN  = 64,
   parameter int unsigned CNT_W = 16
) (
   input logic               clk,
   input logic               rst_n,
   alu_execute_unit_if.slave bus
);

   slice_state_e     state_q;
   logic [XLEN-1:0]  result_q;
   logic             zero_q;
   logic             illegal_q;
   logic [CNT_W-1:0] cnt_q;

   logic [XLEN-1:0]  result_d;
   logic             zero_d;
   logic             illegal_d;
   logic [CNT_W-1:0] cnt_d;
   logic             full;
   logic             ready;
   logic             accept;
   logic             drain;

   alu_core #(
      .XLEN (XLEN)
   ) u_core (
      .alu_ctrl_i (bus.alu_ctrl),
      .a_i        (bus.operand_a),
      .b_i        (bus.operand_b),
      .result_o   (result_d),
      .zero_o     (zero_d),
      .illegal_o  (illegal_d)
   );

   assign full   = (state_q == ST_FULL);
   // Ready looks only at the slice and downstream, never at in_valid
   assign ready  = !full || bus.out_ready;
   assign accept = bus.in_valid && ready;
   assign drain  = full && bus.out_ready;
   assign cnt_d  = cnt_q + CNT_W'(1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_EMPTY;
         result_q  <= '0;
         zero_q    <= 1'b0;
         illegal_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         if (accept) begin
            state_q   <= ST_FULL;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
         end else if (drain) begin
            state_q   <= ST_EMPTY;
         end
         if (drain) begin
            cnt_q <= cnt_d;
         end
      end
   end

   assign bus.in_ready  = ready;
   assign bus.out_valid = full;
   assign bus.result    = result_q;
   assign bus.zero      = zero_q;
   assign bus.illegal   = illegal_q;
   assign bus.op_count  = cnt_q;

endmodule

// File: tb/tb_alu_execute_unit.sv
// Self-checking bench for alu_execute_unit: directed cases plus randomized traffic
// against a scoreboard fed by an arithmetic reference of the ALU rules.
module tb_alu_execute_unit;

   localparam int unsigned XLEN  = 64;
   localparam int unsigned CNT_W = 16;

   typedef struct packed {
      logic [XLEN-1:0] res;
      logic            zero;
      logic            ill;
   } exp_t;

   logic clk;
   logic rst_n;

   alu_execute_unit_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

   alu_execute_unit #(
      .XLEN  (XLEN),
      .CNT_W (CNT_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned     n_cmp;
   int unsigned     n_mis;
   exp_t            sb[$];
   logic [CNT_W-1:0] m_cnt;
   bit              last_acc;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference: the four legal codes by value, everything else illegal
   function automatic exp_t ref_alu(input logic [3:0] c, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      exp_t e;
      e.ill = 1'b0;
      if      (c == 4'd0) e.res = a & b;
      else if (c == 4'd1) e.res = a | b;
      else if (c == 4'd2) e.res = a + b;
      else if (c == 4'd6) e.res = a - b;
      else begin
         e.res = '0;
         e.ill = 1'b1;
      end
      e.zero = !e.ill && (e.res == 0);
      return e;
   endfunction

   task automatic drive(input logic [3:0] c, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input bit v, input bit r);
      bus.alu_ctrl  = c;
      bus.operand_a = a;
      bus.operand_b = b;
      bus.in_valid  = v;
      bus.out_ready = r;
   endtask

   // Check pre-edge outputs, advance one clock, update the scoreboard
   task automatic cycle(input bit pre = 1'b1);
      bit   exp_rdy, acc, drn;
      exp_t e;
      #1;
      exp_rdy = (sb.size() == 0) || bus.out_ready;
      if (pre) begin
         check_eq("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
         check_eq("out_valid", 64'(bus.out_valid), 64'(sb.size() != 0));
         if (sb.size() != 0) begin
            check_eq("result", bus.result, sb[0].res);
            check_eq("zero", 64'(bus.zero), 64'(sb[0].zero));
            check_eq("illegal", 64'(bus.illegal), 64'(sb[0].ill));
         end
      end
      acc = bus.in_valid && exp_rdy && rst_n;
      drn = (sb.size() != 0) && bus.out_ready && rst_n;
      e   = ref_alu(bus.alu_ctrl, bus.operand_a, bus.operand_b);
      @(posedge clk);
      #1;
      if (!rst_n) begin
         sb.delete();
         m_cnt = '0;
      end else begin
         if (drn) begin
            void'(sb.pop_front());
            m_cnt = m_cnt + 1'b1;
         end
         if (acc) sb.push_back(e);
      end
      last_acc = acc;
      if (pre) check_eq("op_count", 64'(bus.op_count), 64'(m_cnt));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive(4'b0010, 64'd3, 64'd4, 1'b1, 1'b1);
      cycle(1'b0);
      cycle(1'b0);
      rst_n = 1'b1;
      drive(4'b0000, '0, '0, 1'b0, 1'b0);
      #1;
      check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check_eq("rst_result", bus.result, 64'd0);
      check_eq("rst_zero", 64'(bus.zero), 64'd0);
      check_eq("rst_illegal", 64'(bus.illegal), 64'd0);
      check_eq("rst_op_count", 64'(bus.op_count), 64'd0);
   endtask

   logic [XLEN-1:0] ra, rb;
   logic [3:0]      rc;
   logic [3:0]      legal_codes [4];

   initial begin
      n_cmp = 0;
      n_mis = 0;
      m_cnt = '0;
      rst_n = 1'b0;
      drive(4'b0000, '0, '0, 1'b0, 1'b0);
      legal_codes[0] = 4'b0000;
      legal_codes[1] = 4'b0001;
      legal_codes[2] = 4'b0010;
      legal_codes[3] = 4'b0110;
      @(posedge clk);
      #1;
      do_reset();

      // ADD 5+7
      drive(4'b0010, 64'd5, 64'd7, 1'b1, 1'b1);
      cycle();
      drive(4'b0000, '0, '0, 1'b0, 1'b1);
      check_eq("add_res", bus.result, 64'd12);
      check_eq("add_zero", 64'(bus.zero), 64'd0);
      check_eq("add_ill", 64'(bus.illegal), 64'd0);
      cycle();
      check_eq("add_cnt", 64'(bus.op_count), 64'd1);

      // SUB equal (beq), SUB wrap, AND, OR, illegal
      drive(4'b0110, 64'h1234, 64'h1234, 1'b1, 1'b1);
      cycle();
      check_eq("beq_res", bus.result, 64'd0);
      check_eq("beq_zero", 64'(bus.zero), 64'd1);
      drive(4'b0110, 64'd0, 64'd1, 1'b1, 1'b1);
      cycle();
      check_eq("subwrap_res", bus.result, {64{1'b1}});
      check_eq("subwrap_zero", 64'(bus.zero), 64'd0);
      drive(4'b0000, 64'hF0F0, 64'hFF00, 1'b1, 1'b1);
      cycle();
      check_eq("and_res", bus.result, 64'hF000);
      drive(4'b0001, 64'hF0F0, 64'hFF00, 1'b1, 1'b1);
      cycle();
      check_eq("or_res", bus.result, 64'hFFF0);
      drive(4'b0011, 64'hF0F0, 64'hFF00, 1'b1, 1'b1);
      cycle();
      check_eq("ill_res", bus.result, 64'd0);
      check_eq("ill_flag", 64'(bus.illegal), 64'd1);
      check_eq("ill_zero", 64'(bus.zero), 64'd0);
      drive(4'b0000, '0, '0, 1'b0, 1'b1);
      cycle();
      check_eq("ill_drained", 64'(bus.out_valid), 64'd0);

      // Backpressure: ADD(1,1) then stall SUB(9,4) for 3 cycles
      do_reset();
      drive(4'b0010, 64'd1, 64'd1, 1'b1, 1'b1);
      cycle();
      drive(4'b0110, 64'd9, 64'd4, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle();
         check_eq("bp_hold_res", bus.result, 64'd2);
         check_eq("bp_hold_rdy", 64'(bus.in_ready), 64'd0);
      end
      bus.out_ready = 1'b1;
      cycle();
      check_eq("bp_sub_res", bus.result, 64'd5);
      check_eq("bp_cnt1", 64'(bus.op_count), 64'd1);
      drive(4'b0000, '0, '0, 1'b0, 1'b1);
      cycle();
      check_eq("bp_cnt2", 64'(bus.op_count), 64'd2);

      // Back-to-back streaming of 8 ADDs
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive(4'b0010, 64'(i), 64'd100, 1'b1, 1'b1);
         cycle();
         check_eq("stream_valid", 64'(bus.out_valid), 64'd1);
         check_eq("stream_res", bus.result, 64'(i + 100));
      end
      drive(4'b0000, '0, '0, 1'b0, 1'b1);
      cycle();
      check_eq("stream_cnt", 64'(bus.op_count), 64'd8);

      // Reset while FULL
      drive(4'b0001, 64'd1, 64'd2, 1'b1, 1'b0);
      cycle();
      check_eq("full_before_rst", 64'(bus.out_valid), 64'd1);
      rst_n = 1'b0;
      cycle(1'b0);
      rst_n = 1'b1;
      drive(4'b0000, '0, '0, 1'b0, 1'b0);
      #1;
      check_eq("rst_full_valid", 64'(bus.out_valid), 64'd0);
      check_eq("rst_full_cnt", 64'(bus.op_count), 64'd0);

      // Randomized traffic; upstream holds an unaccepted request stable
      last_acc = 1'b1;
      for (int n = 0; n < 400; n++) begin
         if (!(bus.in_valid && !last_acc)) begin
            case ($urandom_range(0, 4))
               0:       rc = 4'($urandom_range(0, 15));
               default: rc = legal_codes[$urandom_range(0, 3)];
            endcase
            ra = {$urandom, $urandom};
            rb = ($urandom_range(0, 7) == 0) ? ra : {$urandom, $urandom};
            drive(rc, ra, rb, ($urandom_range(0, 3) != 0), 1'b0);
         end
         bus.out_ready = ($urandom_range(0, 3) != 0);
         rst_n = ($urandom_range(0, 99) != 0);
         cycle();
         rst_n = 1'b1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
